tx_lane_framer: RTL and testbench

//  Drains the TX buffer and frames TLP records onto the physical lanes. Pulls one

---
 rtl/pcie_pkg.sv | 25 ++
 rtl/tx_frm_queue.sv | 56 +++++
 rtl/tx_lane_framer.sv | 188 ++++++++++++++++++
 tb/tb_tx_lane_framer.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// Shared PCIe TX types: buffer record, framing K-symbols, framer states.
// Imported by the TX lane framer and its record queue.
package pcie_pkg;

   typedef struct packed {
      logic        vld;
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } tx_buffer_record;

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;
   localparam logic [7:0] K_PAD = 8'hF7;

   typedef enum logic [2:0] {
      IDLE,
      STP,
      DATA,
      END,
      EDB
   } tx_frm_state_e;

endpackage

// File: rtl/tx_frm_queue.sv
// Small record FIFO between TX buffer reads and the framer FSM.
// Supports same-cycle push and pop; head is visible combinationally.
module tx_frm_queue #(
   parameter int DEPTH = 2,
   parameter int W     = 34,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic          o_vld,
   output logic [CW-1:0] o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = i_pop && (cnt_q != '0);
   assign do_push = i_push && ((cnt_q != CW'(DEPTH)) || do_pop);
   assign o_data  = mem[rd_q];
   assign o_vld   = (cnt_q != '0);
   assign o_count = cnt_q;

   // storage array, no reset needed
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_q] <= i_data;
   end

   // pointers and occupancy
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= nxt(wr_q);
         if (do_pop)  rd_q <= nxt(rd_q);
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/tx_lane_framer.sv
// Frames TX buffer records onto lanes with STP/END, nullifies with EDB.
// Optional TX_FRAMER_STATS_EN adds packet / nullified-packet counters.
module tx_lane_framer
   import pcie_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int Q_DEPTH   = 2
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  tx_buffer_record        i_tbr [0:NUM_LANES/4-1],
   input  logic                   i_empty,
   output logic                   o_ren,
   input  logic                   i_hold,
   output logic                   o_hold_ack,
   output logic [NUM_LANES*8-1:0] o_sym,
   output logic [NUM_LANES-1:0]   o_k,
`ifdef TX_FRAMER_STATS_EN
   output logic [31:0]            o_pkt_cnt,
   output logic [31:0]            o_nul_cnt,
`endif
   output logic                   o_err
);

   localparam int NG = NUM_LANES / 4;
   localparam int DW = NUM_LANES * 8;
   localparam int QW = DW + 2;
   localparam int CW = $clog2(Q_DEPTH + 1);

   tx_frm_state_e state_q;
   tx_frm_state_e state_d;

   logic           inflight_q;
   logic           eop_q;
   logic           eop_d;
   logic           pop;
   logic           err_d;
   logic           ack_d;
   logic           push;
   logic [DW-1:0]  push_data;
   logic [QW-1:0]  push_word;
   logic [QW-1:0]  head_word;
   logic           head_vld;
   logic           head_sop;
   logic           head_eop;
   logic [DW-1:0]  head_data;
   logic [CW-1:0]  q_count;
   logic [CW:0]    occ;
   logic [DW-1:0]  sym_d;
   logic [NUM_LANES-1:0] k_d;

   // gather group data into lane order
   always_comb begin
      push_data = '0;
      for (int g = 0; g < NG; g++) begin
         push_data[32*g +: 32] = i_tbr[g].data;
      end
   end

   assign push      = inflight_q && i_tbr[0].vld;
   assign push_word = {i_tbr[0].sop, i_tbr[0].eop, push_data};
   assign {head_sop, head_eop, head_data} = head_word;

   tx_frm_queue #(
      .DEPTH (Q_DEPTH),
      .W     (QW),
      .CW    (CW)
   ) u_queue (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  (push_word),
      .i_pop   (pop),
      .o_data  (head_word),
      .o_vld   (head_vld),
      .o_count (q_count)
   );

   // a slot freed by this cycle's pop can be refilled right away,
   // so a two-entry queue still streams one record per cycle
   assign occ   = (CW+1)'(q_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign o_ren = !i_rst && !i_empty && (occ < (CW+1)'(Q_DEPTH));

   // track the read whose record returns next cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) inflight_q <= 1'b0;
      else       inflight_q <= o_ren;
   end

   // state and registered lane outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         eop_q      <= 1'b0;
         o_sym      <= '0;
         o_k        <= '0;
         o_err      <= 1'b0;
         o_hold_ack <= 1'b0;
      end else begin
         state_q    <= state_d;
         eop_q      <= eop_d;
         o_sym      <= sym_d;
         o_k        <= k_d;
         o_err      <= err_d;
         o_hold_ack <= ack_d;
      end
   end

   // next state, queue pop and error decision
   always_comb begin
      state_d = state_q;
      eop_d   = eop_q;
      pop     = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (head_vld) begin
               if (!head_sop) begin
                  pop   = 1'b1;
                  err_d = 1'b1;
               end else if (!i_hold) begin
                  state_d = STP;
               end
            end
         end
         STP: begin
            state_d = DATA;
            pop     = 1'b1;
            eop_d   = head_eop;
         end
         DATA: begin
            if (eop_q) begin
               state_d = END;
            end else if (!head_vld || head_sop) begin
               state_d = EDB;
               err_d   = 1'b1;
            end else begin
               pop   = 1'b1;
               eop_d = head_eop;
            end
         end
         END: begin
            if (head_vld && head_sop && !i_hold) state_d = STP;
            else                                 state_d = IDLE;
         end
         EDB: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // lane symbols for the state about to be shown
   always_comb begin
      sym_d = {NUM_LANES{K_PAD}};
      k_d   = '1;
      unique case (state_d)
         STP: sym_d[7:0] = K_STP;
         END: sym_d[7:0] = K_END;
         EDB: sym_d[7:0] = K_EDB;
         DATA: begin
            sym_d = head_data;
            k_d   = '0;
         end
         default: begin
            sym_d = '0;
            k_d   = '0;
         end
      endcase
      ack_d = (state_d == IDLE) && i_hold;
   end

`ifdef TX_FRAMER_STATS_EN
   // framed and nullified packet counters, free-running wrap
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_pkt_cnt <= '0;
         o_nul_cnt <= '0;
      end else begin
         if (state_d == END) o_pkt_cnt <= o_pkt_cnt + 32'd1;
         if (state_d == EDB) o_nul_cnt <= o_nul_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tx_lane_framer.sv
// Directed bench for tx_lane_framer with a simple TX buffer model.
// Define TX_FRAMER_STATS_EN to also check the packet counters.
module tb_tx_lane_framer;
   import pcie_pkg::*;

   localparam logic [31:0] STP_P = 32'hF7F7F7FB;
   localparam logic [31:0] END_P = 32'hF7F7F7FD;
   localparam logic [31:0] EDB_P = 32'hF7F7F7FE;

   logic            i_clk = 1'b0;
   logic            i_rst;
   tx_buffer_record i_tbr [0:0];
   logic            i_empty;
   logic            o_ren;
   logic            i_hold;
   logic            o_hold_ack;
   logic [31:0]     o_sym;
   logic [3:0]      o_k;
   logic            o_err;
`ifdef TX_FRAMER_STATS_EN
   logic [31:0]     o_pkt_cnt;
   logic [31:0]     o_nul_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   tx_buffer_record q[$];

   logic [31:0] lsym [64];
   logic [3:0]  lk   [64];
   logic        lerr [64];
   logic        lren [64];
   logic [35:0] ex   [8];

   tx_lane_framer #(.NUM_LANES(4), .Q_DEPTH(2)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_tbr      (i_tbr),
      .i_empty    (i_empty),
      .o_ren      (o_ren),
      .i_hold     (i_hold),
      .o_hold_ack (o_hold_ack),
      .o_sym      (o_sym),
      .o_k        (o_k),
`ifdef TX_FRAMER_STATS_EN
      .o_pkt_cnt  (o_pkt_cnt),
      .o_nul_cnt  (o_nul_cnt),
`endif
      .o_err      (o_err)
   );

   always #5 i_clk = ~i_clk;

   // TX buffer model: one-cycle read latency, vld=0 when read while empty
   initial begin
      logic rd;
      i_tbr[0] = '0;
      i_empty  = 1'b1;
      forever begin
         @(negedge i_clk);
         rd = o_ren;
         @(posedge i_clk);
         #1;
         if (rd && q.size() > 0) i_tbr[0] = q.pop_front();
         else                    i_tbr[0] = '0;
         i_empty = (q.size() == 0);
      end
   end

   task automatic put(input logic sop, input logic eop, input logic [31:0] d);
      q.push_back({1'b1, sop, eop, d});
   endtask

   task automatic collect(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         lsym[i] = o_sym;
         lk[i]   = o_k;
         lerr[i] = o_err;
         lren[i] = o_ren;
      end
   endtask

   function automatic int find_stp(input int n);
      for (int i = 0; i < n; i++) begin
         if (lk[i] == 4'hF && lsym[i] == STP_P) return i;
      end
      return -1;
   endfunction

   function automatic int err_sum(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += int'(lerr[i]);
      return s;
   endfunction

   task automatic test_reset();
      @(negedge i_clk);
      n_cmp++;
      if (o_sym !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_sym: got %h want %h", o_sym, 32'h0);
      end
      n_cmp++;
      if (o_k !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_k: got %h want %h", o_k, 4'h0);
      end
      n_cmp++;
      if (o_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_err: got %b want 0", o_err);
      end
      n_cmp++;
      if (o_hold_ack !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ack: got %b want 0", o_hold_ack);
      end
      n_cmp++;
      if (o_ren !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ren: got %b want 0", o_ren);
      end
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
   endtask

   task automatic test_three_rec();
      int s;
      int r;
      put(1'b1, 1'b0, 32'h03020100);
      put(1'b0, 1'b0, 32'h13121110);
      put(1'b0, 1'b1, 32'h23222120);
      ex[0] = {4'hF, STP_P};
      ex[1] = {4'h0, 32'h03020100};
      ex[2] = {4'h0, 32'h13121110};
      ex[3] = {4'h0, 32'h23222120};
      ex[4] = {4'hF, END_P};
      ex[5] = {4'h0, 32'h0};
      collect(20);
      s = find_stp(20);
      n_cmp++;
      if (s < 0 || s + 5 >= 20) begin
         n_bad++;
         $display("FAIL three_stp: got index %0d want 0..14", s);
      end else begin
         for (int j = 0; j < 6; j++) begin
            n_cmp++;
            if ({lk[s+j], lsym[s+j]} !== ex[j]) begin
               n_bad++;
               $display("FAIL three_seq%0d: got %h want %h",
                        j, {lk[s+j], lsym[s+j]}, ex[j]);
            end
         end
      end
      n_cmp++;
      if (err_sum(20) !== 0) begin
         n_bad++;
         $display("FAIL three_err: got %0d want 0", err_sum(20));
      end
      r = 0;
      for (int i = 0; i < 20; i++) r += int'(lren[i]);
      n_cmp++;
      if (r < 1) begin
         n_bad++;
         $display("FAIL three_ren: got %0d reads want >=1", r);
      end
   endtask

   task automatic test_single();
      int s;
      put(1'b1, 1'b1, 32'hDEADBEEF);
      ex[0] = {4'hF, STP_P};
      ex[1] = {4'h0, 32'hDEADBEEF};
      ex[2] = {4'hF, END_P};
      ex[3] = {4'h0, 32'h0};
      collect(16);
      s = find_stp(16);
      n_cmp++;
      if (s < 0 || s + 3 >= 16) begin
         n_bad++;
         $display("FAIL single_stp: got index %0d want 0..12", s);
      end else begin
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if ({lk[s+j], lsym[s+j]} !== ex[j]) begin
               n_bad++;
               $display("FAIL single_seq%0d: got %h want %h",
                        j, {lk[s+j], lsym[s+j]}, ex[j]);
            end
         end
      end
   endtask

   task automatic test_underrun();
      int s;
      int nz;
      put(1'b1, 1'b0, 32'hA0A1A2A3);
      ex[0] = {4'hF, STP_P};
      ex[1] = {4'h0, 32'hA0A1A2A3};
      ex[2] = {4'hF, EDB_P};
      ex[3] = {4'h0, 32'h0};
      collect(16);
      s = find_stp(16);
      n_cmp++;
      if (s < 0 || s + 3 >= 16) begin
         n_bad++;
         $display("FAIL under_stp: got index %0d want 0..12", s);
      end else begin
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if ({lk[s+j], lsym[s+j]} !== ex[j]) begin
               n_bad++;
               $display("FAIL under_seq%0d: got %h want %h",
                        j, {lk[s+j], lsym[s+j]}, ex[j]);
            end
         end
         n_cmp++;
         if (lerr[s+2] !== 1'b1) begin
            n_bad++;
            $display("FAIL under_err_edb: got %b want 1", lerr[s+2]);
         end
      end
      n_cmp++;
      if (err_sum(16) !== 1) begin
         n_bad++;
         $display("FAIL under_err_cnt: got %0d want 1", err_sum(16));
      end
      put(1'b0, 1'b1, 32'hB0B1B2B3);
      collect(12);
      nz = 0;
      for (int i = 0; i < 12; i++) begin
         if (lk[i] != 4'h0 || lsym[i] != 32'h0) nz++;
      end
      n_cmp++;
      if (nz !== 0) begin
         n_bad++;
         $display("FAIL orphan_idle: got %0d non-idle cycles want 0", nz);
      end
      n_cmp++;
      if (err_sum(12) !== 1) begin
         n_bad++;
         $display("FAIL orphan_err: got %0d want 1", err_sum(12));
      end
   endtask

   task automatic test_hold();
      @(posedge i_clk);
      #1 i_hold = 1'b1;
      put(1'b1, 1'b1, 32'hC0C1C2C3);
      repeat (8) @(negedge i_clk);
      n_cmp++;
      if (o_hold_ack !== 1'b1) begin
         n_bad++;
         $display("FAIL hold_ack: got %b want 1", o_hold_ack);
      end
      n_cmp++;
      if ({o_k, o_sym} !== 36'h0) begin
         n_bad++;
         $display("FAIL hold_idle: got %h want %h", {o_k, o_sym}, 36'h0);
      end
      @(posedge i_clk);
      #1 i_hold = 1'b0;
      @(negedge i_clk);
      n_cmp++;
      if ({o_k, o_sym} !== 36'h0) begin
         n_bad++;
         $display("FAIL hold_rel0: got %h want %h", {o_k, o_sym}, 36'h0);
      end
      collect(4);
      ex[0] = {4'hF, STP_P};
      ex[1] = {4'h0, 32'hC0C1C2C3};
      ex[2] = {4'hF, END_P};
      ex[3] = {4'h0, 32'h0};
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if ({lk[j], lsym[j]} !== ex[j]) begin
            n_bad++;
            $display("FAIL hold_rel_seq%0d: got %h want %h",
                     j, {lk[j], lsym[j]}, ex[j]);
         end
      end
   endtask

   task automatic test_sop_in_pkt();
      int s;
      put(1'b1, 1'b0, 32'h11223344);
      put(1'b1, 1'b1, 32'h55667788);
      ex[0] = {4'hF, STP_P};
      ex[1] = {4'h0, 32'h11223344};
      ex[2] = {4'hF, EDB_P};
      ex[3] = {4'h0, 32'h0};
      ex[4] = {4'hF, STP_P};
      ex[5] = {4'h0, 32'h55667788};
      ex[6] = {4'hF, END_P};
      ex[7] = {4'h0, 32'h0};
      collect(24);
      s = find_stp(24);
      n_cmp++;
      if (s < 0 || s + 7 >= 24) begin
         n_bad++;
         $display("FAIL sop_stp: got index %0d want 0..16", s);
      end else begin
         for (int j = 0; j < 8; j++) begin
            n_cmp++;
            if ({lk[s+j], lsym[s+j]} !== ex[j]) begin
               n_bad++;
               $display("FAIL sop_seq%0d: got %h want %h",
                        j, {lk[s+j], lsym[s+j]}, ex[j]);
            end
         end
      end
      n_cmp++;
      if (err_sum(24) !== 1) begin
         n_bad++;
         $display("FAIL sop_err_cnt: got %0d want 1", err_sum(24));
      end
   endtask

   task automatic test_rst_mid();
      bit seen;
      int nk;
      put(1'b1, 1'b0, 32'h0D0D0D0D);
      for (int i = 0; i < 5; i++) put(1'b0, 1'b0, 32'h0E0E0E00 + i);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge i_clk);
         if (o_k == 4'h0 && o_sym == 32'h0D0D0D0D) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL rst_mid_data: got no data cycle want D0 within 30");
      end
      i_rst = 1'b1;
      q.delete();
      #1;
      n_cmp++;
      if (o_ren !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_ren0: got %b want 0", o_ren);
      end
      @(negedge i_clk);
      n_cmp++;
      if ({o_k, o_sym} !== 36'h0) begin
         n_bad++;
         $display("FAIL rst_mid_out: got %h want %h", {o_k, o_sym}, 36'h0);
      end
      n_cmp++;
      if (o_ren !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid_ren: got %b want 0", o_ren);
      end
      i_rst = 1'b0;
      collect(12);
      nk = 0;
      for (int i = 0; i < 12; i++) if (lk[i] != 4'h0) nk++;
      n_cmp++;
      if (nk !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_noend: got %0d K cycles want 0", nk);
      end
      n_cmp++;
      if (err_sum(12) !== 0) begin
         n_bad++;
         $display("FAIL rst_mid_err: got %0d want 0", err_sum(12));
      end
   endtask

`ifdef TX_FRAMER_STATS_EN
   task automatic test_stats();
      @(negedge i_clk);
      i_rst = 1'b1;
      q.delete();
      repeat (2) @(negedge i_clk);
      n_cmp++;
      if (o_pkt_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL stats_rst_pkt: got %0d want 0", o_pkt_cnt);
      end
      i_rst = 1'b0;
      for (int i = 0; i < 5; i++) put(1'b1, 1'b1, 32'h50000000 + i);
      repeat (40) @(negedge i_clk);
      put(1'b1, 1'b0, 32'h6A6A6A6A);
      repeat (20) @(negedge i_clk);
      n_cmp++;
      if (o_pkt_cnt !== 32'd5) begin
         n_bad++;
         $display("FAIL stats_pkt: got %0d want 5", o_pkt_cnt);
      end
      n_cmp++;
      if (o_nul_cnt !== 32'd1) begin
         n_bad++;
         $display("FAIL stats_nul: got %0d want 1", o_nul_cnt);
      end
   endtask
`endif

   initial begin
      i_rst  = 1'b1;
      i_hold = 1'b0;
      repeat (2) @(posedge i_clk);
      test_reset();
      test_three_rec();
      test_single();
      test_underrun();
      test_hold();
      test_sop_in_pkt();
      test_rst_mid();
`ifdef TX_FRAMER_STATS_EN
      test_stats();
`endif
      repeat (4) @(negedge i_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
